metropolis_accept: RTL and testbench
====================================

Name: metropolis_accept

Overview:
- Parametrised, pipelined Metropolis acceptance unit for the Ising spin-update datapath. It is the next generation of the combinational spin acceptance LUT.
- Holds a runtime-writable probability table indexed by temperature slot and energy level. It takes (dE, random) requests over a valid/ready handshake and returns accept/reject after two cycles.
- It also keeps request and accept statistics counters.
- Sits between the energy-difference calculator and the spin-lattice write-back.

Parameters:
- PROB_W, 12, width of random value and stored probabilities.
- DE_W, 5, width of signed dE input (two's complement).
- NUM_TEMPS, 4, number of temperature slots in the table (>=1).
- NUM_LEVELS, 2, number of positive energy levels per slot (>=1).
- LEVEL_SHIFT, 1, log2 of energy step between levels (step 2 -> levels dE=2,4).
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  table write strobe
- cfg_temp  in  $clog2(NUM_TEMPS) (min 1)  slot to write
- cfg_level  in  $clog2(NUM_LEVELS) (min 1)  level index to write (0 -> dE=1*step)
- cfg_prob  in  PROB_W  probability value to write
- temp_sel  in  $clog2(NUM_TEMPS) (min 1)  active slot, sampled with each request
- in_valid  in  1  request valid
- in_ready  out  1  request accepted this cycle when high with in_valid
- in_dE  in  DE_W  signed energy difference
- in_random  in  PROB_W  uniform random value
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_accept  out  1  1 = flip spin
- stats_clr  in  1  synchronous clear of counters
- req_count  out  CNT_W  completed results
- acc_count  out  CNT_W  completed accepted results

Behaviour:
- Reset (async, rst_n=0):
  - all table entries = all-ones.
  - pipeline valids = 0; out_valid=0, out_accept=0.
  - counters = 0.
- Pipeline, latency 2 cycles from input handshake to out_valid.
  - S1 registers dE class, the selected table entry and random.
  - S2 registers out_accept.
- Flow control:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advance condition (combinational, no dependency on in_valid).
  - Full throughput of 1 result/cycle when out_ready is held high.
  - Under backpressure out_valid/out_accept stay stable until out_ready.
- dE classification:
  - dE <= 0: accept unconditionally, regardless of random (all-ones random also accepts).
  - dE > 0: k = ceil(dE / 2^LEVEL_SHIFT). Non-multiples round up to the next level.
  - 1 <= k <= NUM_LEVELS: prob = table[temp_sel][k-1]; accept iff in_random < prob (unsigned).
  - k > NUM_LEVELS: reject unconditionally.
- Table writes:
  - cfg_we writes table[cfg_temp][cfg_level] at the clock edge.
  - Out-of-range indices are ignored.
  - A request accepted in the same cycle as a write to the same entry uses the old value. Requests from the next cycle use the new value.
- temp_sel is captured per request, so changing it mid-stream affects only later requests.
- Counters:
  - On out handshake (out_valid && out_ready), req_count += 1, and acc_count += 1 if out_accept.
  - Both saturate at all-ones.
  - stats_clr clears both to 0 and wins over a same-cycle increment.
- rst_n asserted mid-stream drops in-flight results; no output handshake occurs for them.

Optional Feature:
- Macro: METROPOLIS_LFSR_EN.
- Defined:
  - Adds an internal Galois LFSR, LFSR_W = max(16, PROB_W) bits, reset seed all-ones except bit 0 = 0.
  - Steps once per input handshake.
  - Its low PROB_W bits replace in_random, which is ignored.
- Undefined: no LFSR logic; in_random is used directly.

Decomposition:
- Package spin_pkg:
  - PROB_ONE(all-ones) helper function.
  - LFSR tap constants per width (16, 24, 32).
  - dE class enum: DE_NONPOS, DE_LEVEL, DE_OVER.
  - Index-width helper function (clog2, min 1).
- Sub-module metropolis_lfsr (width, seed, step enable, state output), instantiated only under METROPOLIS_LFSR_EN.

Test Plan:
- After reset, dE=0, random=0xFFF -> accept=1 after 2 cycles; dE=2, random=0xFFE -> accept=1; dE=2, random=0xFFF -> accept=0 (entries all-ones).
- Write table[0][0]=0x04B, table[0][1]=0x002, temp_sel=0:
  - dE=2: random=0x04A -> 1; random=0x04B -> 0.
  - dE=4: random=0x001 -> 1; random=0x002 -> 0.
  - dE=3 -> uses level 1 (0x002).
- dE=6 (k=3 > NUM_LEVELS) with random=0 -> accept=0; dE=-4 with random=0xFFF -> accept=1.
- Stream 8 requests back-to-back with out_ready toggling 1,0,0,1:
  - no loss or reordering; in_ready low only when both stages are full and stalled.
  - req_count=8; acc_count matches the model.
- Write to table[1][0] in the same cycle as a request on slot 1, level 0 -> old value used; the next request uses the new value. stats_clr in the same cycle as a handshake -> counters read 0.
- rst_n pulse low with 2 requests in flight -> out_valid=0 immediately, counters 0, no stale result after release; with METROPOLIS_LFSR_EN, first 4 outputs match the reference LFSR sequence.

Source files
------------

// File: rtl/spin_pkg.sv
// Shared types and helpers for the Ising spin-update datapath.
package spin_pkg;

   // Classification of an energy difference before the table lookup.
   typedef enum logic [1:0] {
      DE_NONPOS = 2'd0,
      DE_LEVEL  = 2'd1,
      DE_OVER   = 2'd2
   } de_class_e;

   // Galois LFSR feedback masks (right-shifting form) for supported widths.
   localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
   localparam logic [31:0] LFSR_TAPS_24 = 32'h00E1_0000;
   localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

   // Index width for an n-entry dimension; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // All-ones probability ("certain accept") for a w-bit value, w <= 32.
   function automatic logic [31:0] prob_one(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   // Feedback mask for a given LFSR width; other widths fall back to 16.
   function automatic logic [31:0] lfsr_taps(input int w);
      case (w)
         24:      return LFSR_TAPS_24;
         32:      return LFSR_TAPS_32;
         default: return LFSR_TAPS_16;
      endcase
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/metropolis_lfsr.sv
// Galois LFSR random source; advances one step per asserted step strobe.
module metropolis_lfsr #(
   parameter int           W    = 16,
   parameter logic [W-1:0] SEED = {W{1'b1}},
   parameter logic [W-1:0] TAPS = {W{1'b0}}
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         step,
   output logic [W-1:0] state
);

   logic [W-1:0] state_q;

   // Shift right, folding the taps in when the outgoing bit is set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEED;
      end else if (step) begin
         state_q <= state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
      end
   end

   assign state = state_q;

endmodule

// File: rtl/metropolis_accept.sv
// Pipelined Metropolis acceptance unit with writable probability table.
// Optional build macro METROPOLIS_LFSR_EN replaces in_random with an
// internal LFSR stream.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and its data stable until that edge; ready never
// depends on valid. out_valid/out_accept hold until out_ready takes them.
module metropolis_accept
   import spin_pkg::*;
#(
   parameter int PROB_W      = 12,
   parameter int DE_W        = 5,
   parameter int NUM_TEMPS   = 4,
   parameter int NUM_LEVELS  = 2,
   parameter int LEVEL_SHIFT = 1,
   parameter int CNT_W       = 32
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cfg_we,
   input  logic [idx_w(NUM_TEMPS)-1:0]  cfg_temp,
   input  logic [idx_w(NUM_LEVELS)-1:0] cfg_level,
   input  logic [PROB_W-1:0]            cfg_prob,
   input  logic [idx_w(NUM_TEMPS)-1:0]  temp_sel,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DE_W-1:0]              in_dE,
   input  logic [PROB_W-1:0]            in_random,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_accept,
   input  logic                         stats_clr,
   output logic [CNT_W-1:0]             req_count,
   output logic [CNT_W-1:0]             acc_count
);

   localparam int TW = idx_w(NUM_TEMPS);
   localparam int LW = idx_w(NUM_LEVELS);
   localparam int KW = DE_W + 1;
   localparam logic [PROB_W-1:0] PONE  = PROB_W'(prob_one(PROB_W));
   localparam logic [KW-1:0]     ROUND = KW'((1 << LEVEL_SHIFT) - 1);

   logic [PROB_W-1:0] prob_tab [0:NUM_TEMPS-1][0:NUM_LEVELS-1];

   logic              in_hs, s1_adv, s2_adv, out_hs, s1_hit;
   logic [KW-1:0]     de_ext, k_val;
   logic [LW-1:0]     lvl;
   de_class_e         cls;
   logic [PROB_W-1:0] sel_prob, rnd;

   logic              s1_valid, s2_valid, s2_accept;
   de_class_e         s1_cls;
   logic [PROB_W-1:0] s1_prob, s1_rnd;
   logic [CNT_W-1:0]  req_q, acc_q;

   assign s2_adv   = !s2_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;
   assign in_hs    = in_valid && in_ready;
   assign out_hs   = s2_valid && out_ready;

`ifdef METROPOLIS_LFSR_EN
   localparam int                LFSR_W    = max_int(16, PROB_W);
   localparam logic [LFSR_W-1:0] LFSR_SEED = {{(LFSR_W-1){1'b1}}, 1'b0};
   localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(lfsr_taps(LFSR_W));

   logic [LFSR_W-1:0] lfsr_state;
   logic              unused_bits;

   metropolis_lfsr #(
      .W    (LFSR_W),
      .SEED (LFSR_SEED),
      .TAPS (LFSR_TAPS)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .step  (in_hs),
      .state (lfsr_state)
   );

   assign rnd         = lfsr_state[PROB_W-1:0];
   assign unused_bits = ^{lfsr_state, in_random};
`else
   assign rnd = in_random;
`endif

   // Table write port; out-of-range indices are dropped. Reads below see the
   // pre-edge contents, so a same-cycle request gets the old entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < NUM_TEMPS; t++)
            for (int l = 0; l < NUM_LEVELS; l++)
               prob_tab[t][l] <= PONE;
      end else if (cfg_we && (32'(cfg_temp) < 32'(NUM_TEMPS))
                          && (32'(cfg_level) < 32'(NUM_LEVELS))) begin
         prob_tab[cfg_temp][cfg_level] <= cfg_prob;
      end
   end

   // Classify dE, round positive values up to a level and fetch its entry.
   always_comb begin
      de_ext   = {in_dE[DE_W-1], in_dE};
      k_val    = (de_ext + ROUND) >> LEVEL_SHIFT;
      cls      = DE_NONPOS;
      lvl      = '0;
      sel_prob = '0;
      if (in_dE[DE_W-1] || (in_dE == '0)) begin
         cls = DE_NONPOS;
      end else if (k_val > KW'(NUM_LEVELS)) begin
         cls = DE_OVER;
      end else begin
         cls = DE_LEVEL;
         lvl = LW'(k_val - KW'(1));
         if (32'(temp_sel) < 32'(NUM_TEMPS))
            sel_prob = prob_tab[temp_sel][lvl];
      end
   end

   // Stage 1: capture class, table entry and random per accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_cls   <= DE_NONPOS;
         s1_prob  <= '0;
         s1_rnd   <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_cls  <= cls;
            s1_prob <= sel_prob;
            s1_rnd  <= rnd;
         end
      end
   end

   assign s1_hit = (s1_cls == DE_NONPOS) ||
                   ((s1_cls == DE_LEVEL) && (s1_rnd < s1_prob));

   // Stage 2: register the decision; holds while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_accept <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid)
            s2_accept <= s1_hit;
      end
   end

   // Saturating statistics on output handshakes; clear takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q <= '0;
         acc_q <= '0;
      end else if (stats_clr) begin
         req_q <= '0;
         acc_q <= '0;
      end else if (out_hs) begin
         if (req_q != '1)
            req_q <= req_q + CNT_W'(1);
         if (s2_accept && (acc_q != '1))
            acc_q <= acc_q + CNT_W'(1);
      end
   end

   assign out_valid  = s2_valid;
   assign out_accept = s2_accept;
   assign req_count  = req_q;
   assign acc_count  = acc_q;

endmodule

// File: tb/tb_metropolis_accept.sv
// Self-checking bench for metropolis_accept (also valid with
// METROPOLIS_LFSR_EN defined: the model then tracks the LFSR stream).
module tb_metropolis_accept;

   localparam int PROB_W     = 12;
   localparam int DE_W       = 5;
   localparam int NUM_TEMPS  = 4;
   localparam int NUM_LEVELS = 2;
   localparam int CNT_W      = 32;

   logic              clk, rst_n;
   logic              cfg_we;
   logic [1:0]        cfg_temp;
   logic [0:0]        cfg_level;
   logic [PROB_W-1:0] cfg_prob;
   logic [1:0]        temp_sel;
   logic              in_valid, in_ready;
   logic [DE_W-1:0]   in_dE;
   logic [PROB_W-1:0] in_random;
   logic              out_valid, out_ready, out_accept;
   logic              stats_clr;
   logic [CNT_W-1:0]  req_count, acc_count;

   int total = 0;
   int bad   = 0;

   logic [0:0]        exp_q [$];
   logic [PROB_W-1:0] model_tab [0:NUM_TEMPS-1][0:NUM_LEVELS-1];
   int                req_m, acc_m;
   logic [15:0]       lfsr_m;
   logic              prev_stall, prev_acc, mon_e;

   metropolis_accept #(
      .PROB_W(PROB_W), .DE_W(DE_W), .NUM_TEMPS(NUM_TEMPS),
      .NUM_LEVELS(NUM_LEVELS), .LEVEL_SHIFT(1), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_temp(cfg_temp), .cfg_level(cfg_level),
      .cfg_prob(cfg_prob), .temp_sel(temp_sel),
      .in_valid(in_valid), .in_ready(in_ready), .in_dE(in_dE),
      .in_random(in_random), .out_valid(out_valid), .out_ready(out_ready),
      .out_accept(out_accept), .stats_clr(stats_clr),
      .req_count(req_count), .acc_count(acc_count)
   );

   // Clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   // Reference model
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   function automatic logic model_acc(input logic signed [4:0] de,
                                      input logic [PROB_W-1:0] r, input int t);
      int d, k;
      d = int'(de);
      if (d <= 0) return 1'b1;
      k = (d + 1) / 2;
      if (k > NUM_LEVELS) return 1'b0;
      return (r < model_tab[t][k-1]);
   endfunction

   task automatic model_reset();
      for (int t = 0; t < NUM_TEMPS; t++)
         for (int l = 0; l < NUM_LEVELS; l++)
            model_tab[t][l] = 12'hFFF;
      exp_q.delete();
      req_m      = 0;
      acc_m      = 0;
      lfsr_m     = 16'hFFFE;
      prev_stall = 1'b0;
   endtask

   // Scoreboard monitor: samples 3 time units after each rising edge, when
   // outputs and the inputs for the coming edge are both settled.
   always begin
      @(posedge clk);
      #3;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         total++;
         if (in_ready !== !((exp_q.size() == 2) && !out_ready)) begin
            bad++;
            $display("FAIL in_ready_occupancy: got %b required %b (inflight=%0d out_ready=%b)",
                     in_ready, !((exp_q.size() == 2) && !out_ready), exp_q.size(), out_ready);
         end
         if (prev_stall) begin
            total++;
            if (out_valid !== 1'b1 || out_accept !== prev_acc) begin
               bad++;
               $display("FAIL stall_stable: got valid=%b accept=%b required valid=1 accept=%b",
                        out_valid, out_accept, prev_acc);
            end
         end
         mon_e = 1'b0;
         if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_out: got accept=%b required no output", out_accept);
            end else begin
               mon_e = exp_q.pop_front();
               if (out_accept !== mon_e) begin
                  bad++;
                  $display("FAIL out_accept: got %b required %b", out_accept, mon_e);
               end
            end
         end
         if (stats_clr) begin
            req_m = 0;
            acc_m = 0;
         end else if (out_valid && out_ready) begin
            req_m++;
            if (mon_e) acc_m++;
         end
         prev_stall = out_valid && !out_ready;
         prev_acc   = out_accept;
      end
   end

   // Driver tasks
   task automatic send(input logic signed [4:0] de, input logic [PROB_W-1:0] r,
                       input logic [1:0] t);
      logic [PROB_W-1:0] r_eff;
      int n;
      in_valid  = 1'b1;
      in_dE     = de;
      in_random = r;
      temp_sel  = t;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready=%b required 1 within 100 cycles", in_ready);
         in_valid = 1'b0;
         return;
      end
`ifdef METROPOLIS_LFSR_EN
      r_eff  = lfsr_m[PROB_W-1:0];
      lfsr_m = lfsr_next(lfsr_m);
`else
      r_eff = r;
`endif
      exp_q.push_back(model_acc(de, r_eff, int'(t)));
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] t, input logic [0:0] l,
                            input logic [PROB_W-1:0] p);
      cfg_we    = 1'b1;
      cfg_temp  = t;
      cfg_level = l;
      cfg_prob  = p;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      model_tab[t][l] = p;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #4;
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_counts(input int req_exp, input int acc_exp);
      total++;
      if (req_count !== CNT_W'(req_exp)) begin
         bad++;
         $display("FAIL req_count: got %0d required %0d", req_count, req_exp);
      end
      total++;
      if (acc_count !== CNT_W'(acc_exp)) begin
         bad++;
         $display("FAIL acc_count: got %0d required %0d", acc_count, acc_exp);
      end
   endtask

   // Scenarios
   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #22;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      total++;
      if (out_valid !== 1'b0 || out_accept !== 1'b0) begin
         bad++;
         $display("FAIL reset_out: got valid=%b accept=%b required 0/0", out_valid, out_accept);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
      check_counts(0, 0);
   endtask

   task automatic test_latency();
      send(5'sd0, 12'hFFF, 2'd0);
      idle();
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL latency_cycle1: out_valid got %b required 0", out_valid);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL latency_cycle2: out_valid got %b required 1", out_valid);
      end
      wait_drain();
   endtask

   task automatic test_default_table();
      send(5'sd2, 12'hFFE, 2'd0);
      send(5'sd2, 12'hFFF, 2'd0);
      idle();
      wait_drain();
   endtask

   task automatic test_table_levels();
      cfg_write(2'd0, 1'b0, 12'h04B);
      cfg_write(2'd0, 1'b1, 12'h002);
      send(5'sd2,  12'h04A, 2'd0);
      send(5'sd2,  12'h04B, 2'd0);
      send(5'sd4,  12'h001, 2'd0);
      send(5'sd4,  12'h002, 2'd0);
      send(5'sd3,  12'h001, 2'd0);
      send(5'sd3,  12'h002, 2'd0);
      send(5'sd1,  12'h04A, 2'd0);
      send(5'sd6,  12'h000, 2'd0);
      send(5'sd15, 12'h000, 2'd0);
      send(-5'sd4, 12'hFFF, 2'd0);
      send(-5'sd16, 12'hFFF, 2'd0);
      send(5'sd2,  12'h04A, 2'd3);
      idle();
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int start_acc;
      stats_clr = 1'b1;
      @(posedge clk);
      #1;
      stats_clr = 1'b0;
      cfg_write(2'd1, 1'b1, 12'h800);
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(5'($urandom_range(0, 31)), 12'($urandom_range(0, 4095)),
                    2'($urandom_range(0, 1)));
            idle();
         end
         begin
            for (int c = 0; c < 24; c++) begin
               out_ready = ((c % 4) == 0) || ((c % 4) == 3);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();
      start_acc = acc_m;
      check_counts(8, start_acc);
   endtask

   task automatic test_same_cycle_write();
      cfg_we    = 1'b1;
      cfg_temp  = 2'd1;
      cfg_level = 1'b0;
      cfg_prob  = 12'h100;
      send(5'sd2, 12'h200, 2'd1);
      cfg_we = 1'b0;
      model_tab[1][0] = 12'h100;
      send(5'sd2, 12'h200, 2'd1);
      send(5'sd1, 12'h0FF, 2'd1);
      idle();
      wait_drain();
   endtask

   task automatic test_stats_clr();
      send(-5'sd1, 12'h000, 2'd2);
      idle();
      @(posedge clk);
      #1;
      stats_clr = 1'b1;
      @(posedge clk);
      #1;
      stats_clr = 1'b0;
      check_counts(0, 0);
      wait_drain();
      send(-5'sd1, 12'h000, 2'd2);
      idle();
      wait_drain();
      check_counts(1, 1);
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b1;
      send(5'sd0, 12'h123, 2'd0);
      send(5'sd0, 12'h456, 2'd0);
      idle();
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL midreset_out_valid: got %b required 0", out_valid);
      end
      check_counts(0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL midreset_stale: out_valid got %b required 0", out_valid);
      end
      check_counts(0, 0);
      for (int i = 0; i < 4; i++)
         send(5'sd2, 12'(12'h400 * i + 12'h3FF), 2'd0);
      idle();
      wait_drain();
      check_counts(4, acc_m);
   endtask

   initial begin
      rst_n     = 1'b0;
      cfg_we    = 1'b0;
      cfg_temp  = '0;
      cfg_level = '0;
      cfg_prob  = '0;
      temp_sel  = '0;
      in_valid  = 1'b0;
      in_dE     = '0;
      in_random = '0;
      out_ready = 1'b1;
      stats_clr = 1'b0;

      test_reset();
      test_latency();
      test_default_table();
      test_table_levels();
      test_back_to_back();
      test_same_cycle_write();
      test_stats_clr();
      test_reset_midstream();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
